// File: rtl/wb_stage_reg_pkg.sv
// Shared constants and types for the MEM/WB write-back stage.
package wb_stage_reg_pkg;

    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [4:0]  NOPRegAddr = 5'd0;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    // InstretBus: retired-instruction counter, bits 63:0
    typedef logic [63:0] instret_bus_t;

    localparam int MaxLanes = 4;
    // Wide enough to hold a popcount of up to MaxLanes lanes
    localparam int CntW = 3;

endpackage

// File: rtl/wb_lane_sanitise.sv
// Combinational write-enable sanitiser: drops invalid, x0 and shadowed
// lane writes, and counts the valid lanes for instret.
module wb_lane_sanitise
    import wb_stage_reg_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int ADDR_W = 5
) (
    input  logic [LANES-1:0]        mem_valid,
    input  logic [LANES*ADDR_W-1:0] mem_wd,
    input  logic [LANES-1:0]        mem_wreg,
    output logic [LANES-1:0]        wreg_san,
    output logic [CntW-1:0]         valid_cnt
);

    logic [LANES-1:0] wreg_raw;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic shadowed;

            assign wreg_raw[gi] = (mem_wreg[gi] == WriteEnable) & mem_valid[gi]
                                & (mem_wd[gi*ADDR_W +: ADDR_W] != '0);

            // A later lane writing the same register makes this write dead
            always_comb begin
                shadowed = 1'b0;
                for (int j = gi + 1; j < LANES; j++) begin
                    if (wreg_raw[j] &&
                        (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[gi*ADDR_W +: ADDR_W])) begin
                        shadowed = 1'b1;
                    end
                end
            end

            assign wreg_san[gi] = wreg_raw[gi] & ~shadowed;
        end
    endgenerate

    always_comb begin
        valid_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            valid_cnt = valid_cnt + CntW'(mem_valid[i]);
        end
    end

endmodule

// File: rtl/wb_stage_reg.sv
// Multi-lane MEM/WB pipeline register with flush, stall handling,
// write-enable sanitising and a 64-bit retired-instruction counter.
module wb_stage_reg
    import wb_stage_reg_pkg::*;
#(
    parameter int LANES     = 1,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        mem_valid,
    input  logic [LANES*ADDR_W-1:0] mem_wd,
    input  logic [LANES-1:0]        mem_wreg,
    input  logic [LANES*DATA_W-1:0] mem_wdata,
    input  logic [STALL_W-1:0]      stall,
    input  logic                    flush,
    output logic [LANES-1:0]        wb_valid,
    output logic [LANES*ADDR_W-1:0] wb_wd,
    output logic [LANES-1:0]        wb_wreg,
    output logic [LANES*DATA_W-1:0] wb_wdata,
    output logic [63:0]             instret
);

    generate
        if (STAGE_IDX < 0 || STAGE_IDX > STALL_W - 2 || LANES < 1 || LANES > MaxLanes) begin : g_param_check
            $error("wb_stage_reg: illegal LANES or STAGE_IDX");
        end
    endgenerate

    logic s_cur;
    logic s_nxt;
    logic unused_stall;

    assign s_cur = stall[STAGE_IDX];
    assign s_nxt = stall[STAGE_IDX+1];
    // Only two bits of the shared stall vector matter to this stage
    assign unused_stall = ^stall;

    logic [LANES-1:0] wreg_san;
    logic [CntW-1:0]  valid_cnt;

    wb_lane_sanitise #(
        .LANES (LANES),
        .ADDR_W(ADDR_W)
    ) u_sanitise (
        .mem_valid(mem_valid),
        .mem_wd   (mem_wd),
        .mem_wreg (mem_wreg),
        .wreg_san (wreg_san),
        .valid_cnt(valid_cnt)
    );

    logic [LANES-1:0]        wb_valid_reg;
    logic [LANES*ADDR_W-1:0] wb_wd_reg;
    logic [LANES-1:0]        wb_wreg_reg;
    logic [LANES*DATA_W-1:0] wb_wdata_reg;
    instret_bus_t            instret_reg;
    instret_bus_t            instret_next;

    assign instret_next = instret_reg + instret_bus_t'(valid_cnt);

    // Flush beats stall; a stalled stage with a running successor drains to a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_reg <= '0;
            wb_wd_reg    <= '0;
            wb_wreg_reg  <= '0;
            wb_wdata_reg <= '0;
            instret_reg  <= '0;
        end else if (flush || (s_cur == Stop && s_nxt == NoStop)) begin
            wb_valid_reg <= '0;
            wb_wd_reg    <= '0;
            wb_wreg_reg  <= '0;
            wb_wdata_reg <= '0;
        end else if (s_cur == NoStop) begin
            wb_valid_reg <= mem_valid;
            wb_wd_reg    <= mem_wd;
            wb_wreg_reg  <= wreg_san;
            wb_wdata_reg <= mem_wdata;
            instret_reg  <= instret_next;
        end
    end

    assign wb_valid = wb_valid_reg;
    assign wb_wd    = wb_wd_reg;
    assign wb_wreg  = wb_wreg_reg;
    assign wb_wdata = wb_wdata_reg;
    assign instret  = instret_reg;

endmodule
